// File: rtl/b_code_time_keeper.sv
// b_code_time_keeper
// Latches range-checked IRIG-B decoded time frames and runs a local BCD
// time-of-day / day-of-year / year clock from a 1 s tick, tracking
// SYNC / HOLDOVER / UNSYNC status and emitting a 1PPS strobe.
//
// Optional feature macro: B_CODE_CONTINUITY_CHECK_EN
//   Defined: while SYNC or HOLDOVER, a valid frame loads only if it equals the
//   local time or it is the 3rd consecutive mismatching valid frame.
//
// Ports:
//   pll_c0               system clock
//   pll_locked           asynchronous active-low reset
//   decode_done          one-cycle strobe, decoded fields stable
//   in_*                 decoded BCD fields (seconds..year)
//   miao_*/fen_*/shi_*/day_*/year_*  local running time (BCD)
//   pps_out              one-cycle pulse per local second increment
//   sync_state           00 UNSYNC, 01 SYNC, 10 HOLDOVER
//   err_cnt              saturating count of rejected frames
module b_code_time_keeper #(
    parameter logic [31:0] CNT_1S_MAX   = 32'd124_999,
    parameter logic [7:0]  HOLDOVER_MAX = 8'd10
) (
    input  logic       pll_c0,
    input  logic       pll_locked,
    input  logic       decode_done,
    input  logic [3:0] in_miao_gewei,
    input  logic [2:0] in_miao_shiwei,
    input  logic [3:0] in_fen_gewei,
    input  logic [2:0] in_fen_shiwei,
    input  logic [3:0] in_shi_gewei,
    input  logic [1:0] in_shi_shiwei,
    input  logic [3:0] in_day_gewei,
    input  logic [3:0] in_day_shiwei,
    input  logic [1:0] in_day_baiwei,
    input  logic [3:0] in_year_gewei,
    input  logic [3:0] in_year_shiwei,
    output logic [3:0] miao_gewei,
    output logic [2:0] miao_shiwei,
    output logic [3:0] fen_gewei,
    output logic [2:0] fen_shiwei,
    output logic [3:0] shi_gewei,
    output logic [1:0] shi_shiwei,
    output logic [3:0] day_gewei,
    output logic [3:0] day_shiwei,
    output logic [1:0] day_baiwei,
    output logic [3:0] year_gewei,
    output logic [3:0] year_shiwei,
    output logic       pps_out,
    output logic [1:0] sync_state,
    output logic [7:0] err_cnt
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned MISS_W = 8;
    localparam int unsigned DAY_W  = 10;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_SYNC   = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    // Full local time, most significant digit first.
    typedef struct packed {
        logic [3:0] y_s;
        logic [3:0] y_g;
        logic [1:0] d_b;
        logic [3:0] d_s;
        logic [3:0] d_g;
        logic [1:0] h_s;
        logic [3:0] h_g;
        logic [2:0] m_s;
        logic [3:0] m_g;
        logic [2:0] s_s;
        logic [3:0] s_g;
    } tod_t;

    localparam tod_t TOD_RESET = '{y_s: 4'd0, y_g: 4'd0, d_b: 2'd0, d_s: 4'd0, d_g: 4'd1,
                                   h_s: 2'd0, h_g: 4'd0, m_s: 3'd0, m_g: 4'd0,
                                   s_s: 3'd0, s_g: 4'd0};

    state_t              state;
    state_t              state_nxt;
    tod_t                tod;
    tod_t                frame;
    logic [CNT_W-1:0]    cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic                load_pend;
    logic                tick;
    logic                frame_ok;
    logic                do_load;
    logic [DAY_W-1:0]    day_bin;
    logic [DAY_W-1:0]    day_lim;

    // Leap year: tens even with units 0/4/8, or tens odd with units 2/6.
    function automatic logic leap_year(input logic [3:0] ys, input logic [3:0] yg);
        return (!ys[0] && (yg == 4'd0 || yg == 4'd4 || yg == 4'd8)) ||
               ( ys[0] && (yg == 4'd2 || yg == 4'd6));
    endfunction

    // Last day of the current year (365, or 366 in leap years).
    function automatic logic day_end(input tod_t t);
        return (t.d_b == 2'd3) && (t.d_s == 4'd6) &&
               (t.d_g == (leap_year(t.y_s, t.y_g) ? 4'd6 : 4'd5));
    endfunction

    // One-second BCD increment with ripple carry through to the year.
    function automatic tod_t inc_time(input tod_t t);
        tod_t r;
        logic c;
        r = t;
        c = (t.s_g == 4'd9);
        r.s_g = c ? 4'd0 : t.s_g + 4'd1;
        if (c) begin
            c = (t.s_s == 3'd5);
            r.s_s = c ? 3'd0 : t.s_s + 3'd1;
        end
        if (c) begin
            c = (t.m_g == 4'd9);
            r.m_g = c ? 4'd0 : t.m_g + 4'd1;
        end
        if (c) begin
            c = (t.m_s == 3'd5);
            r.m_s = c ? 3'd0 : t.m_s + 3'd1;
        end
        if (c) begin
            if (t.h_s == 2'd2 && t.h_g == 4'd3) begin
                r.h_s = 2'd0;
                r.h_g = 4'd0;
            end else begin
                c = 1'b0;
                if (t.h_g == 4'd9) begin
                    r.h_g = 4'd0;
                    r.h_s = t.h_s + 2'd1;
                end else begin
                    r.h_g = t.h_g + 4'd1;
                end
            end
        end
        if (c) begin
            if (day_end(t)) begin
                r.d_b = 2'd0;
                r.d_s = 4'd0;
                r.d_g = 4'd1;
            end else begin
                c = 1'b0;
                if (t.d_g == 4'd9) begin
                    r.d_g = 4'd0;
                    if (t.d_s == 4'd9) begin
                        r.d_s = 4'd0;
                        r.d_b = t.d_b + 2'd1;
                    end else begin
                        r.d_s = t.d_s + 4'd1;
                    end
                end else begin
                    r.d_g = t.d_g + 4'd1;
                end
            end
        end
        if (c) begin
            r.y_g = (t.y_g == 4'd9) ? 4'd0 : t.y_g + 4'd1;
            if (t.y_g == 4'd9) begin
                r.y_s = (t.y_s == 4'd9) ? 4'd0 : t.y_s + 4'd1;
            end
        end
        return r;
    endfunction

    assign frame = '{y_s: in_year_shiwei, y_g: in_year_gewei,
                     d_b: in_day_baiwei, d_s: in_day_shiwei, d_g: in_day_gewei,
                     h_s: in_shi_shiwei, h_g: in_shi_gewei,
                     m_s: in_fen_shiwei, m_g: in_fen_gewei,
                     s_s: in_miao_shiwei, s_g: in_miao_gewei};

    assign tick = (cnt == CNT_1S_MAX);

    // Range check of the decoded frame.
    always_comb begin
        day_bin  = DAY_W'(frame.d_b) * 10'd100 + DAY_W'(frame.d_s) * 10'd10 + DAY_W'(frame.d_g);
        day_lim  = leap_year(frame.y_s, frame.y_g) ? 10'd366 : 10'd365;
        frame_ok = (frame.s_g <= 4'd9) && (frame.s_s <= 3'd5) &&
                   (frame.m_g <= 4'd9) && (frame.m_s <= 3'd5) &&
                   (frame.h_g <= 4'd9) &&
                   ((frame.h_s < 2'd2) || (frame.h_s == 2'd2 && frame.h_g <= 4'd3)) &&
                   (frame.d_g <= 4'd9) && (frame.d_s <= 4'd9) &&
                   (day_bin != 10'd0) && (day_bin <= day_lim) &&
                   (frame.y_g <= 4'd9) && (frame.y_s <= 4'd9);
    end

`ifdef B_CODE_CONTINUITY_CHECK_EN
    logic [1:0] mis_cnt;
    logic       match;

    assign match = (frame == tod);

    // Locked states accept only continuous frames, or the 3rd mismatch in a row.
    always_comb begin
        do_load = decode_done && frame_ok &&
                  ((state == ST_UNSYNC) || match || (mis_cnt == 2'd2));
    end

    // Consecutive mismatching-frame counter.
    always_ff @(posedge pll_c0 or negedge pll_locked) begin
        if (!pll_locked) begin
            mis_cnt <= 2'd0;
        end else if (decode_done && frame_ok) begin
            if (do_load) begin
                mis_cnt <= 2'd0;
            end else begin
                mis_cnt <= mis_cnt + 2'd1;
            end
        end
    end
`else
    assign do_load = decode_done && frame_ok;
`endif

    // Sync status register.
    always_ff @(posedge pll_c0 or negedge pll_locked) begin
        if (!pll_locked) begin
            state <= ST_UNSYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Sync status next-state.
    always_comb begin
        state_nxt = state;
        if (do_load) begin
            state_nxt = ST_SYNC;
        end else begin
            case (state)
                ST_SYNC:   if (miss_cnt >= 8'd2)         state_nxt = ST_HOLD;
                ST_HOLD:   if (miss_cnt >= HOLDOVER_MAX) state_nxt = ST_UNSYNC;
                ST_UNSYNC: state_nxt = ST_UNSYNC;
                default:   state_nxt = ST_UNSYNC;
            endcase
        end
    end

    // Time, 1 s counter, miss/error counters and PPS.
    always_ff @(posedge pll_c0 or negedge pll_locked) begin
        if (!pll_locked) begin
            tod       <= TOD_RESET;
            cnt       <= '0;
            miss_cnt  <= '0;
            load_pend <= 1'b0;
            pps_out   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            pps_out <= 1'b0;
            cnt     <= tick ? '0 : cnt + 32'd1;
            if (do_load) begin
                // Load wins over a coincident tick; the +1 s follows next cycle.
                tod       <= frame;
                cnt       <= '0;
                miss_cnt  <= '0;
                load_pend <= 1'b1;
            end else if (load_pend) begin
                tod       <= inc_time(tod);
                pps_out   <= 1'b1;
                load_pend <= 1'b0;
            end else if (tick) begin
                tod     <= inc_time(tod);
                pps_out <= 1'b1;
                if (miss_cnt != 8'hFF) begin
                    miss_cnt <= miss_cnt + 8'd1;
                end
            end
            if (decode_done && !do_load && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign year_shiwei = tod.y_s;
    assign year_gewei  = tod.y_g;
    assign day_baiwei  = tod.d_b;
    assign day_shiwei  = tod.d_s;
    assign day_gewei   = tod.d_g;
    assign shi_shiwei  = tod.h_s;
    assign shi_gewei   = tod.h_g;
    assign fen_shiwei  = tod.m_s;
    assign fen_gewei   = tod.m_g;
    assign miao_shiwei = tod.s_s;
    assign miao_gewei  = tod.s_g;
    assign sync_state  = 2'(state);

endmodule

// File: tb/tb_b_code_time_keeper.sv
// tb_b_code_time_keeper
// Directed bench for b_code_time_keeper with a 100-cycle second.
// Time values are written as 11 hex nibbles: YY DDD HH MM SS.
module tb_b_code_time_keeper;

    logic       clk = 1'b0;
    logic       pll_locked = 1'b0;
    logic       decode_done = 1'b0;
    logic [3:0] in_miao_gewei = '0;
    logic [2:0] in_miao_shiwei = '0;
    logic [3:0] in_fen_gewei = '0;
    logic [2:0] in_fen_shiwei = '0;
    logic [3:0] in_shi_gewei = '0;
    logic [1:0] in_shi_shiwei = '0;
    logic [3:0] in_day_gewei = '0;
    logic [3:0] in_day_shiwei = '0;
    logic [1:0] in_day_baiwei = '0;
    logic [3:0] in_year_gewei = '0;
    logic [3:0] in_year_shiwei = '0;
    logic [3:0] miao_gewei;
    logic [2:0] miao_shiwei;
    logic [3:0] fen_gewei;
    logic [2:0] fen_shiwei;
    logic [3:0] shi_gewei;
    logic [1:0] shi_shiwei;
    logic [3:0] day_gewei;
    logic [3:0] day_shiwei;
    logic [1:0] day_baiwei;
    logic [3:0] year_gewei;
    logic [3:0] year_shiwei;
    logic       pps_out;
    logic [1:0] sync_state;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    b_code_time_keeper #(
        .CNT_1S_MAX  (32'd99),
        .HOLDOVER_MAX(8'd10)
    ) dut (
        .pll_c0        (clk),
        .pll_locked    (pll_locked),
        .decode_done   (decode_done),
        .in_miao_gewei (in_miao_gewei),
        .in_miao_shiwei(in_miao_shiwei),
        .in_fen_gewei  (in_fen_gewei),
        .in_fen_shiwei (in_fen_shiwei),
        .in_shi_gewei  (in_shi_gewei),
        .in_shi_shiwei (in_shi_shiwei),
        .in_day_gewei  (in_day_gewei),
        .in_day_shiwei (in_day_shiwei),
        .in_day_baiwei (in_day_baiwei),
        .in_year_gewei (in_year_gewei),
        .in_year_shiwei(in_year_shiwei),
        .miao_gewei    (miao_gewei),
        .miao_shiwei   (miao_shiwei),
        .fen_gewei     (fen_gewei),
        .fen_shiwei    (fen_shiwei),
        .shi_gewei     (shi_gewei),
        .shi_shiwei    (shi_shiwei),
        .day_gewei     (day_gewei),
        .day_shiwei    (day_shiwei),
        .day_baiwei    (day_baiwei),
        .year_gewei    (year_gewei),
        .year_shiwei   (year_shiwei),
        .pps_out       (pps_out),
        .sync_state    (sync_state),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    // Local time packed as YY DDD HH MM SS nibbles.
    function automatic logic [43:0] now();
        return {year_shiwei, year_gewei, 2'b00, day_baiwei, day_shiwei, day_gewei,
                2'b00, shi_shiwei, shi_gewei, 1'b0, fen_shiwei, fen_gewei,
                1'b0, miao_shiwei, miao_gewei};
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic drive_frame(input logic [43:0] f);
        in_year_shiwei = f[43:40];
        in_year_gewei  = f[39:36];
        in_day_baiwei  = 2'(f[35:32]);
        in_day_shiwei  = f[31:28];
        in_day_gewei   = f[27:24];
        in_shi_shiwei  = 2'(f[23:20]);
        in_shi_gewei   = f[19:16];
        in_fen_shiwei  = 3'(f[15:12]);
        in_fen_gewei   = f[11:8];
        in_miao_shiwei = 3'(f[7:4]);
        in_miao_gewei  = f[3:0];
        decode_done    = 1'b1;
        @(negedge clk);
        decode_done    = 1'b0;
    endtask

    // Reset, released on a negedge.
    task automatic do_reset();
        decode_done = 1'b0;
        pll_locked  = 1'b0;
        repeat (2) @(negedge clk);
        pll_locked  = 1'b1;
    endtask

    task automatic test_reset();
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (now() !== 44'h00001000000) begin errors++; $display("FAIL reset_time: got %h expected %h", now(), 44'h00001000000); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL reset_pps: got %b expected 0", pps_out); end
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL reset_sync: got %b expected 00", sync_state); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        pll_locked = 1'b1;
    endtask

    task automatic test_free_run();
        repeat (99) @(negedge clk);
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL free_pps_early: got %b expected 0", pps_out); end
        checks++; if (now() !== 44'h00001000000) begin errors++; $display("FAIL free_time0: got %h expected %h", now(), 44'h00001000000); end
        @(negedge clk);
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL free_pps1: got %b expected 1", pps_out); end
        checks++; if (now() !== 44'h00001000001) begin errors++; $display("FAIL free_time1: got %h expected %h", now(), 44'h00001000001); end
        repeat (100) @(negedge clk);
        checks++; if (now() !== 44'h00001000002) begin errors++; $display("FAIL free_time2: got %h expected %h", now(), 44'h00001000002); end
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL free_pps2: got %b expected 1", pps_out); end
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL free_sync: got %b expected 00", sync_state); end
    endtask

    task automatic test_rollover();
        drive_frame(44'h21365235958);
        @(negedge clk);
        checks++; if (now() !== 44'h21365235959) begin errors++; $display("FAIL roll_pre: got %h expected %h", now(), 44'h21365235959); end
        repeat (98) @(negedge clk);
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL roll_pps_early: got %b expected 0", pps_out); end
        @(negedge clk);
        checks++; if (now() !== 44'h22001000000) begin errors++; $display("FAIL roll_year: got %h expected %h", now(), 44'h22001000000); end
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL roll_pps: got %b expected 1", pps_out); end
    endtask

    task automatic test_valid_load();
        do_reset();
        drive_frame(44'h24060123456);
        checks++; if (now() !== 44'h24060123456) begin errors++; $display("FAIL load_raw: got %h expected %h", now(), 44'h24060123456); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL load_pps_n: got %b expected 0", pps_out); end
        @(negedge clk);
        checks++; if (now() !== 44'h24060123457) begin errors++; $display("FAIL load_plus1: got %h expected %h", now(), 44'h24060123457); end
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL load_pps: got %b expected 1", pps_out); end
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL load_sync: got %b expected 01", sync_state); end
        drive_frame(44'h24365235959);
        @(negedge clk);
        checks++; if (now() !== 44'h24366000000) begin errors++; $display("FAIL leap_366: got %h expected %h", now(), 44'h24366000000); end
        drive_frame(44'h24366235958);
        @(negedge clk);
        repeat (99) @(negedge clk);
        checks++; if (now() !== 44'h25001000000) begin errors++; $display("FAIL leap_wrap: got %h expected %h", now(), 44'h25001000000); end
        drive_frame(44'h99365235959);
        @(negedge clk);
        checks++; if (now() !== 44'h00001000000) begin errors++; $display("FAIL year99_wrap: got %h expected %h", now(), 44'h00001000000); end
    endtask

    task automatic test_invalid();
        do_reset();
        drive_frame(44'h21100102030);
        @(negedge clk);
        drive_frame(44'h21100102060);
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bad_sec_err: got %0d expected 1", err_cnt); end
        checks++; if (now() !== 44'h21100102031) begin errors++; $display("FAIL bad_sec_time: got %h expected %h", now(), 44'h21100102031); end
        drive_frame(44'h23366102030);
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL bad_day366_err: got %0d expected 2", err_cnt); end
        drive_frame(44'h21100242030);
        drive_frame(44'h21100102A30);
        drive_frame(44'h21000102030);
        checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL bad_misc_err: got %0d expected 5", err_cnt); end
        checks++; if (now() !== 44'h21100102031) begin errors++; $display("FAIL bad_time_hold: got %h expected %h", now(), 44'h21100102031); end
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL bad_sync: got %b expected 01", sync_state); end
        repeat (260) drive_frame(44'h21100102060);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d expected 255", err_cnt); end
    endtask

    task automatic test_holdover();
        do_reset();
        drive_frame(44'h21100102030);
        @(negedge clk);
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL hold_sync0: got %b expected 01", sync_state); end
        repeat (199) @(negedge clk);
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL hold_early: got %b expected 01", sync_state); end
        @(negedge clk);
        checks++; if (sync_state !== 2'b10) begin errors++; $display("FAIL hold_enter: got %b expected 10", sync_state); end
        repeat (799) @(negedge clk);
        checks++; if (sync_state !== 2'b10) begin errors++; $display("FAIL hold_stay: got %b expected 10", sync_state); end
        @(negedge clk);
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL hold_unsync: got %b expected 00", sync_state); end
        drive_frame(44'h21100102030);
        @(negedge clk);
        checks++; if (sync_state !== 2'b01) begin errors++; $display("FAIL hold_resync: got %b expected 01", sync_state); end
    endtask

    task automatic test_load_on_tick();
        do_reset();
        repeat (99) @(negedge clk);
        drive_frame(44'h21100102030);
        checks++; if (now() !== 44'h21100102030) begin errors++; $display("FAIL tick_load_raw: got %h expected %h", now(), 44'h21100102030); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL tick_load_pps_n: got %b expected 0", pps_out); end
        @(negedge clk);
        checks++; if (now() !== 44'h21100102031) begin errors++; $display("FAIL tick_load_plus1: got %h expected %h", now(), 44'h21100102031); end
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL tick_load_pps: got %b expected 1", pps_out); end
        @(negedge clk);
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL tick_load_single: got %b expected 0", pps_out); end
        repeat (97) @(negedge clk);
        checks++; if (now() !== 44'h21100102031) begin errors++; $display("FAIL tick_load_hold: got %h expected %h", now(), 44'h21100102031); end
        @(negedge clk);
        checks++; if (now() !== 44'h21100102032) begin errors++; $display("FAIL tick_load_next: got %h expected %h", now(), 44'h21100102032); end
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL tick_load_next_pps: got %b expected 1", pps_out); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (37) @(negedge clk);
        drive_frame(44'h21100102030);
        pll_locked = 1'b0;
        #1;
        checks++; if (now() !== 44'h00001000000) begin errors++; $display("FAIL rst_time: got %h expected %h", now(), 44'h00001000000); end
        checks++; if (sync_state !== 2'b00) begin errors++; $display("FAIL rst_sync: got %b expected 00", sync_state); end
        @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        checks++; if (now() !== 44'h00001000000) begin errors++; $display("FAIL rst_no_pend: got %h expected %h", now(), 44'h00001000000); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL rst_pps: got %b expected 0", pps_out); end
        repeat (99) @(negedge clk);
        checks++; if (now() !== 44'h00001000001) begin errors++; $display("FAIL rst_first_tick: got %h expected %h", now(), 44'h00001000001); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_rollover();
        test_valid_load();
        test_invalid();
        test_holdover();
        test_load_on_tick();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
